// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone transmitter: default
// parameters, controller state encoding and a counter-width helper.
package pdm_pkg;

    localparam int C_W_DEF   = 12;
    localparam int C_OSR_DEF = 64;
    localparam int C_TMO_DEF = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } pdm_state_t;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pdm_sdm2.sv
// Second-order sigma-delta modulator with saturating integrators.
// The output bit register doubles as the feedback memory for the next step.
module pdm_sdm2 #(
    parameter int C_W = 12
) (
    input  logic                  CK_i,
    input  logic                  XARST_i,
    input  logic                  EN_i,
    input  logic                  CLR_i,
    input  logic signed [C_W-1:0] X_i,
    output logic                  BIT_o
);

    localparam int AW = C_W + 6;
    // Two guard bits so the unsaturated sums can never overflow.
    localparam int EW = C_W + 8;

    localparam logic signed [EW-1:0] FB_MAG = EW'(2 ** (C_W - 1));
    localparam logic signed [EW-1:0] I_MAX  = EW'(2 ** (AW - 1) - 1);
    localparam logic signed [EW-1:0] I_MIN  = ~I_MAX;

    logic signed [AW-1:0] i1_q;
    logic signed [AW-1:0] i2_q;
    logic signed [AW-1:0] i1_d;
    logic signed [AW-1:0] i2_d;
    logic                 bit_q;
    logic                 bit_d;
    logic signed [EW-1:0] fb;
    logic signed [EW-1:0] x_e;
    logic signed [EW-1:0] s1;
    logic signed [EW-1:0] s2;

    function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [AW-1:0] r;
        if (v > I_MAX) begin
            r = I_MAX[AW-1:0];
        end else if (v < I_MIN) begin
            r = I_MIN[AW-1:0];
        end else begin
            r = v[AW-1:0];
        end
        return r;
    endfunction

    // Next integrator values and output bit from the current state and input.
    always_comb begin
        fb    = bit_q ? FB_MAG : -FB_MAG;
        x_e   = {{(EW - C_W){X_i[C_W-1]}}, X_i};
        s1    = {{2{i1_q[AW-1]}}, i1_q} + x_e - fb;
        i1_d  = sat(s1);
        s2    = {{2{i2_q[AW-1]}}, i2_q} + {{2{i1_d[AW-1]}}, i1_d} - fb;
        i2_d  = sat(s2);
        bit_d = ~i2_d[AW-1];
    end

    // Integrator and bit registers; clear wins over a step.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else if (CLR_i) begin
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else if (EN_i) begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            bit_q <= bit_d;
        end
    end

    assign BIT_o = bit_q;

endmodule

// File: rtl/pdm_mic_tx.sv
// PDM microphone transmitter: buffers PCM samples in a 2-entry FIFO,
// follows the master's PDM clock and drives one modulated bit per PDM
// period into the selected half-period slot.
//
//   state | meaning
//   IDLE  | no PDM clock seen, outputs quiet
//   SYNC  | an edge was seen, waiting for a rising edge to align
//   RUN   | one modulator step per rising edge, data slot driven
module pdm_mic_tx
    import pdm_pkg::*;
#(
    parameter int C_W   = C_W_DEF,
    parameter int C_OSR = C_OSR_DEF,
    parameter int C_TMO = C_TMO_DEF
) (
    input  logic                  CK_i,
    input  logic                  XARST_i,
    input  logic                  PDM_CK_i,
    input  logic                  SEL_i,
    input  logic signed [C_W-1:0] PCM_DAT_i,
    input  logic                  PCM_VLD_i,
    output logic                  PCM_RDY_o,
    output logic                  DAT_o,
    output logic                  DAT_OE_o,
    output logic                  ACT_o,
    output logic                  UDR_o
);

    localparam int SW = cnt_w(C_OSR);
    localparam int TW = cnt_w(C_TMO + 1);
    localparam logic [SW-1:0] S_LAST = SW'(C_OSR - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(C_TMO);

    logic [2:0]            pck_q;
    logic                  rise;
    logic                  fall;
    logic                  any_edge;
    logic [TW-1:0]         tmo_q;
    logic                  tmo_hit;
    pdm_state_t            state_q;
    pdm_state_t            state_d;
    logic                  run;
    logic                  leave;
    logic                  step;
    logic                  wrap;
    logic [SW-1:0]         smp_q;
    logic signed [C_W-1:0] mem_q [2];
    logic                  rd_q;
    logic [1:0]            fcnt_q;
    logic                  push;
    logic                  pop_ok;
    logic signed [C_W-1:0] x_q;
    logic                  udr_q;
    logic                  oe_q;
    logic                  bit_w;

    // Two synchronizer flops plus one history flop for edge detection.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            pck_q <= '0;
        end else begin
            pck_q <= {pck_q[1:0], PDM_CK_i};
        end
    end

    assign rise     = pck_q[1] & ~pck_q[2];
    assign fall     = ~pck_q[1] & pck_q[2];
    assign any_edge = rise | fall;

    // Clock-loss timer: reloaded by every edge, expires after C_TMO quiet cycles.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            tmo_q <= '0;
        end else if (any_edge) begin
            tmo_q <= T_LOAD;
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - 1'b1;
        end
    end

    assign tmo_hit = ~any_edge & (tmo_q == TW'(1));

    // State register.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; clock loss overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_edge) state_d = ST_SYNC;
            ST_SYNC: if (rise)     state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end
    end

    assign run   = (state_q == ST_RUN);
    assign leave = run & (state_d != ST_RUN);
    assign step  = run & rise;
    assign wrap  = step & (smp_q == S_LAST);

    // Position within the current PCM sample, in PDM periods.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            smp_q <= '0;
        end else if (leave) begin
            smp_q <= '0;
        end else if (step) begin
            smp_q <= wrap ? '0 : smp_q + 1'b1;
        end
    end

    assign PCM_RDY_o = (fcnt_q < 2'd2);
    assign push      = PCM_VLD_i & PCM_RDY_o;
    assign pop_ok    = wrap & (fcnt_q != 2'd0);

    // Input FIFO; the write slot is derived from read pointer and fill level.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                mem_q[rd_q ^ fcnt_q[0]] <= PCM_DAT_i;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            fcnt_q <= fcnt_q + 2'(push) - 2'(pop_ok);
        end
    end

    // Current sample and sticky underrun; an empty pop keeps the old sample.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            x_q   <= '0;
            udr_q <= 1'b0;
        end else begin
            if (pop_ok) begin
                x_q <= mem_q[rd_q];
            end
            if (wrap && (fcnt_q == 2'd0)) begin
                udr_q <= 1'b1;
            end
        end
    end

    // Slot enable: SEL_i is only looked at on an edge, so changes apply there.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            oe_q <= 1'b0;
        end else if (!run || leave) begin
            oe_q <= 1'b0;
        end else if (rise) begin
            oe_q <= ~SEL_i;
        end else if (fall) begin
            oe_q <= SEL_i;
        end
    end

    pdm_sdm2 #(
        .C_W(C_W)
    ) u_sdm2 (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .EN_i    (step),
        .CLR_i   (leave),
        .X_i     (x_q),
        .BIT_o   (bit_w)
    );

    // The modulator bit is cleared whenever RUN is left, so it is 0 outside RUN.
    assign DAT_o    = bit_w;
    assign DAT_OE_o = oe_q;
    assign ACT_o    = run;
    assign UDR_o    = udr_q;

endmodule

// File: tb/tb_pdm_mic_tx.sv
// Randomized bench for pdm_mic_tx with a per-PDM-edge behavioural model.
module tb_pdm_mic_tx;

    localparam int W    = 12;
    localparam int OSR  = 64;
    localparam int TMO  = 63;
    localparam int IMAX = (1 << 17) - 1;
    localparam int IMIN = -(1 << 17);
    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_RUN  = 2;

    logic                CK_i      = 1'b0;
    logic                XARST_i   = 1'b0;
    logic                PDM_CK_i  = 1'b0;
    logic                SEL_i     = 1'b0;
    logic signed [W-1:0] PCM_DAT_i = '0;
    logic                PCM_VLD_i = 1'b0;
    logic                PCM_RDY_o;
    logic                DAT_o;
    logic                DAT_OE_o;
    logic                ACT_o;
    logic                UDR_o;

    pdm_mic_tx #(
        .C_W   (W),
        .C_OSR (OSR),
        .C_TMO (TMO)
    ) dut (
        .CK_i      (CK_i),
        .XARST_i   (XARST_i),
        .PDM_CK_i  (PDM_CK_i),
        .SEL_i     (SEL_i),
        .PCM_DAT_i (PCM_DAT_i),
        .PCM_VLD_i (PCM_VLD_i),
        .PCM_RDY_o (PCM_RDY_o),
        .DAT_o     (DAT_o),
        .DAT_OE_o  (DAT_OE_o),
        .ACT_o     (ACT_o),
        .UDR_o     (UDR_o)
    );

    always #10 CK_i = ~CK_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, advanced once per PDM edge.
    int m_state, m_cnt, m_x, m_i1, m_i2, m_bit, m_oe, m_udr, m_step;
    int m_q[$];
    int feed_mode = 0;   // 0 none, 1 keep full with feed_val, 2 random + push at wrap
    int feed_val  = 0;
    bit sel_rand  = 1'b0;
    bit count_en  = 1'b0;
    int ones = 0;
    int bits = 0;

    function automatic int sat(input int v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    task automatic m_reset();
        m_state = M_IDLE; m_cnt = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
        m_bit = 0; m_oe = 0; m_udr = 0; m_step = 0;
        m_q.delete();
    endtask

    task automatic m_timeout();
        m_state = M_IDLE; m_cnt = 0; m_i1 = 0; m_i2 = 0; m_bit = 0; m_oe = 0;
    endtask

    task automatic m_edge(input bit r);
        int fb;
        m_step = 0;
        case (m_state)
            M_IDLE: m_state = M_SYNC;
            M_SYNC: if (r) m_state = M_RUN;
            default: begin
                if (r) begin
                    fb    = (m_bit != 0) ? 2048 : -2048;
                    m_i1  = sat(m_i1 + m_x - fb);
                    m_i2  = sat(m_i2 + m_i1 - fb);
                    m_bit = (m_i2 >= 0) ? 1 : 0;
                    m_step = 1;
                    if (m_cnt == OSR - 1) begin
                        m_cnt = 0;
                        if (m_q.size() > 0) m_x = m_q.pop_front();
                        else m_udr = 1;
                    end else begin
                        m_cnt++;
                    end
                    m_oe = SEL_i ? 0 : 1;
                end else begin
                    m_oe = SEL_i ? 1 : 0;
                end
            end
        endcase
    endtask

    function automatic int next_val();
        if (feed_mode == 2) return int'($urandom_range(0, 4095)) - 2048;
        return feed_val;
    endfunction

    // One PDM half period of 6 CK, entered and left on a CK negedge.
    task automatic half(input bit lvl);
        bit wp;
        int v;
        PDM_CK_i  = lvl;
        PCM_VLD_i = 1'b0;
        wp = (feed_mode == 2) && lvl && (m_state == M_RUN) && (m_cnt == OSR - 1) && (m_q.size() == 1);
        m_edge(lvl);
        if (wp) begin
            // push lands on the same CK edge as the pop
            @(posedge CK_i); @(posedge CK_i);
            @(negedge CK_i);
            v = next_val();
            PCM_DAT_i = v[W-1:0];
            PCM_VLD_i = 1'b1;
            @(posedge CK_i);
            @(negedge CK_i);
            PCM_VLD_i = 1'b0;
            m_q.push_back(v);
            @(posedge CK_i); @(posedge CK_i);
        end else begin
            repeat (5) @(posedge CK_i);
        end
        @(negedge CK_i);
        chk("oe", 32'(DAT_OE_o), 32'(m_oe));
        if (m_state != M_RUN || m_oe != 0)
            chk("dat", 32'(DAT_o), (m_state == M_RUN) ? 32'(m_bit) : 32'd0);
        chk("act", 32'(ACT_o), (m_state == M_RUN) ? 32'd1 : 32'd0);
        chk("udr", 32'(UDR_o), 32'(m_udr));
        chk("rdy", 32'(PCM_RDY_o), (m_q.size() < 2) ? 32'd1 : 32'd0);
        if (count_en && lvl && m_step != 0) begin
            bits++;
            if (DAT_o) ones++;
        end
        if ((feed_mode == 1 && m_q.size() < 2) || (feed_mode == 2 && m_q.size() == 0)) begin
            v = next_val();
            PCM_DAT_i = v[W-1:0];
            PCM_VLD_i = 1'b1;
            m_q.push_back(v);
        end
        if (sel_rand) SEL_i = 1'($urandom_range(0, 1));
        @(posedge CK_i);
        @(negedge CK_i);
        PCM_VLD_i = 1'b0;
    endtask

    task automatic period(input int n);
        repeat (n) begin
            half(1'b1);
            half(1'b0);
        end
    endtask

    task automatic do_reset();
        XARST_i   = 1'b0;
        PDM_CK_i  = 1'b0;
        PCM_VLD_i = 1'b0;
        repeat (2) @(negedge CK_i);
        m_reset();
        XARST_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, drop, guard;
        m_reset();
        XARST_i = 1'b0;
        repeat (3) @(negedge CK_i);
        chk("rst_rdy", 32'(PCM_RDY_o), 32'd1);
        chk("rst_oe",  32'(DAT_OE_o),  32'd0);
        chk("rst_dat", 32'(DAT_o),     32'd0);
        chk("rst_act", 32'(ACT_o),     32'd0);
        chk("rst_udr", 32'(UDR_o),     32'd0);
        XARST_i = 1'b1;
        @(negedge CK_i);

        // FIFO fill with no PDM clock, VLD held one extra cycle while full.
        s0 = int'($urandom_range(0, 4095)) - 2048;
        s1 = int'($urandom_range(0, 4095)) - 2048;
        s2 = int'($urandom_range(0, 4095)) - 2048;
        PCM_DAT_i = s0[W-1:0];
        PCM_VLD_i = 1'b1;
        @(posedge CK_i); @(negedge CK_i);
        chk("rdy_one", 32'(PCM_RDY_o), 32'd1);
        PCM_DAT_i = s1[W-1:0];
        @(posedge CK_i); @(negedge CK_i);
        chk("rdy_full", 32'(PCM_RDY_o), 32'd0);
        PCM_DAT_i = s2[W-1:0];
        @(posedge CK_i); @(negedge CK_i);
        PCM_VLD_i = 1'b0;
        chk("rdy_hold", 32'(PCM_RDY_o), 32'd0);
        m_q.push_back(s0);
        m_q.push_back(s1);

        // Random samples, random slot select, simultaneous push/pop at wraps.
        feed_mode = 2;
        sel_rand  = 1'b1;
        period(450);

        // Underrun with SEL=1, then reset in the middle of a driven low half.
        sel_rand = 1'b0;
        SEL_i    = 1'b1;
        feed_mode = 0;
        do_reset();
        period(70);
        chk("udr_sticky", 32'(UDR_o), 32'd1);
        PDM_CK_i = 1'b0;
        m_edge(1'b0);
        repeat (5) @(posedge CK_i);
        @(negedge CK_i);
        chk("oe_pre_rst", 32'(DAT_OE_o), 32'd1);
        #3 XARST_i = 1'b0;
        #1;
        chk("arst_oe",  32'(DAT_OE_o),  32'd0);
        chk("arst_dat", 32'(DAT_o),     32'd0);
        chk("arst_act", 32'(ACT_o),     32'd0);
        chk("arst_udr", 32'(UDR_o),     32'd0);
        chk("arst_rdy", 32'(PCM_RDY_o), 32'd1);
        m_reset();
        @(negedge CK_i);
        XARST_i = 1'b1;
        period(3);
        chk("run_after_rst", 32'(ACT_o), 32'd1);

        // Zero input: ones density near one half over 256 PDM periods.
        SEL_i = 1'b0;
        do_reset();
        feed_mode = 1;
        feed_val  = 0;
        ones = 0; bits = 0;
        count_en = 1'b1;
        guard = 0;
        while (bits < 256 && guard < 400) begin
            period(1);
            guard++;
        end
        count_en = 1'b0;
        chk("zero_bits", 32'(bits), 32'd256);
        chk("zero_ones_in_range", (ones >= 126 && ones <= 130) ? 32'd1 : 32'd0, 32'd1);

        // Full-scale positive input: near all ones once the sample is loaded.
        do_reset();
        feed_mode = 1;
        feed_val  = 2047;
        guard = 0;
        while (m_x != 2047 && guard < 200) begin
            period(1);
            guard++;
        end
        ones = 0; bits = 0;
        count_en = 1'b1;
        guard = 0;
        while (bits < 512 && guard < 700) begin
            period(1);
            guard++;
        end
        count_en = 1'b0;
        chk("max_bits", 32'(bits), 32'd512);
        chk("max_density", (ones * 100 >= bits * 99 && bits > 0) ? 32'd1 : 32'd0, 32'd1);

        // PDM clock stops high: clock loss after C_TMO cycles past the edge pulse.
        feed_mode = 0;
        PDM_CK_i = 1'b1;
        m_edge(1'b1);
        drop = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge CK_i);
            @(negedge CK_i);
            if (!ACT_o) begin
                drop = k;
                break;
            end
        end
        chk("tmo_cycles", 32'(drop), 32'(TMO + 3));
        chk("tmo_oe",  32'(DAT_OE_o), 32'd0);
        chk("tmo_dat", 32'(DAT_o),    32'd0);
        m_timeout();
        feed_mode = 1;
        half(1'b0);
        chk("restart_sync", 32'(ACT_o), 32'd0);
        half(1'b1);
        chk("restart_run", 32'(ACT_o), 32'd1);
        half(1'b0);
        period(20);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
